// File: rtl/prioritized_dispatcher_if.sv
// Handshake bundle between one upstream word stream and the dispatcher's output channels.
interface prioritized_dispatcher_if #(
  parameter int data_width        = 8,
  parameter int number_of_outputs = 4
);
  localparam int sel_width = $clog2(number_of_outputs);

  logic [data_width-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  channel_enable [number_of_outputs];
  logic [data_width-1:0] out_data       [number_of_outputs];
  logic                  out_valid      [number_of_outputs];
  logic                  out_ready      [number_of_outputs];
  logic [sel_width-1:0]  last_channel;
  logic                  dispatch_pulse;

  modport master (
    output in_data, in_valid, channel_enable, out_ready,
    input  in_ready, out_data, out_valid, last_channel, dispatch_pulse
  );

  modport slave (
    input  in_data, in_valid, channel_enable, out_ready,
    output in_ready, out_data, out_valid, last_channel, dispatch_pulse
  );
endinterface

// File: rtl/prioritized_dispatcher.sv
// Fixed-priority dispatcher: each accepted word lands in the highest-priority enabled
// channel whose one-entry holding register is free (or draining this cycle).
module prioritized_dispatcher #(
  parameter int data_width        = 8,
  parameter int number_of_outputs = 4,
  parameter int priority_list [number_of_outputs] = '{0, 1, 2, 3}
) (
  input  logic clk,
  input  logic rst_n,
  prioritized_dispatcher_if.slave bus
);
  localparam int sel_width = $clog2(number_of_outputs);

  logic [number_of_outputs-1:0] eligible;
  logic [number_of_outputs-1:0] write_sel;
  logic [sel_width-1:0]         target;
  logic [sel_width-1:0]         idx;
  logic                         any_eligible;
  logic                         dispatch;

  // Later entries of priority_list overwrite earlier ones, so the last eligible entry wins.
  always_comb begin
    eligible     = '0;
    write_sel    = '0;
    target       = '0;
    idx          = '0;
    any_eligible = 1'b0;
    for (int c = 0; c < number_of_outputs; c++) begin
      eligible[c] = bus.channel_enable[c] && (!bus.out_valid[c] || bus.out_ready[c]);
    end
    for (int i = 0; i < number_of_outputs; i++) begin
      idx = sel_width'(priority_list[i]);
      if (eligible[idx]) begin
        target       = idx;
        any_eligible = 1'b1;
      end
    end
    dispatch = bus.in_valid && any_eligible && rst_n;
    for (int c = 0; c < number_of_outputs; c++) begin
      write_sel[c] = dispatch && (target == sel_width'(c));
    end
  end

  assign bus.in_ready = any_eligible && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < number_of_outputs; c++) begin
        bus.out_valid[c] <= 1'b0;
        bus.out_data[c]  <= '0;
      end
      bus.last_channel   <= '0;
      bus.dispatch_pulse <= 1'b0;
    end else begin
      bus.dispatch_pulse <= dispatch;
      if (dispatch) begin
        bus.last_channel <= target;
      end
      // A write to a draining channel keeps it full; other drained channels empty.
      for (int c = 0; c < number_of_outputs; c++) begin
        if (write_sel[c]) begin
          bus.out_data[c]  <= bus.in_data;
          bus.out_valid[c] <= 1'b1;
        end else if (bus.out_ready[c]) begin
          bus.out_valid[c] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_prioritized_dispatcher.sv
// Directed scenarios plus a random phase, checked every cycle against a channel-level
// model that scans the channels in the order 3, 1, 2, 0.
module tb_prioritized_dispatcher;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int          high_to_low [4] = '{3, 1, 2, 0};
  logic        m_valid [4];
  logic [7:0]  m_data  [4];
  int          m_last;
  logic        m_pulse;
  logic        m_acc;

  prioritized_dispatcher_if #(.data_width(8), .number_of_outputs(4)) bus ();

  prioritized_dispatcher #(
    .data_width       (8),
    .number_of_outputs(4),
    .priority_list    ('{0, 2, 1, 3})
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_valid[c] = 1'b0;
      m_data[c]  = 8'h00;
    end
    m_last  = 0;
    m_pulse = 1'b0;
    m_acc   = 1'b0;
  endtask

  function automatic int model_target();
    int t;
    t = -1;
    for (int k = 0; k < 4; k++) begin
      if (t < 0 && bus.channel_enable[high_to_low[k]] &&
          (!m_valid[high_to_low[k]] || bus.out_ready[high_to_low[k]]))
        t = high_to_low[k];
    end
    return t;
  endfunction

  task automatic checkModel(input string phase);
    checkOutput({phase, ".in_ready"}, 32'(bus.in_ready), 32'(rst_n && (model_target() >= 0)));
    checkOutput({phase, ".pulse"}, 32'(bus.dispatch_pulse), 32'(m_pulse));
    checkOutput({phase, ".last"}, 32'(bus.last_channel), 32'(m_last));
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("%s.valid%0d", phase, c), 32'(bus.out_valid[c]), 32'(m_valid[c]));
      if (m_valid[c])
        checkOutput($sformatf("%s.data%0d", phase, c), 32'(bus.out_data[c]), 32'(m_data[c]));
    end
  endtask

  // Evaluates the dispatch decision on pre-edge inputs, then advances the model at the edge.
  task automatic tick();
    int   t;
    logic acc;
    t   = model_target();
    acc = rst_n && bus.in_valid && (t >= 0);
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      for (int c = 0; c < 4; c++)
        if (m_valid[c] && bus.out_ready[c]) m_valid[c] = 1'b0;
      if (acc) begin
        m_valid[t] = 1'b1;
        m_data[t]  = bus.in_data;
        m_last     = t;
      end
      m_pulse = acc;
      m_acc   = acc;
    end
    #1;
  endtask

  task automatic applyStimulus(input string phase, input logic v, input logic [7:0] d,
                               input logic [3:0] en, input logic [3:0] rdy);
    bus.in_valid = v;
    bus.in_data  = d;
    for (int c = 0; c < 4; c++) begin
      bus.channel_enable[c] = en[c];
      bus.out_ready[c]      = rdy[c];
    end
    @(negedge clk);
    checkModel(phase);
    tick();
  endtask

  initial begin
    logic [7:0] words [5];
    logic       v;
    logic [7:0] d;
    checks = 0;
    errors = 0;
    words[0] = 8'd1; words[1] = 8'd3; words[2] = 8'd5; words[3] = 8'd7; words[4] = 8'd9;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int c = 0; c < 4; c++) begin
      bus.channel_enable[c] = 1'b1;
      bus.out_ready[c]      = 1'b0;
    end
    model_clear();

    #12;
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'(0));
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("reset.valid%0d", c), 32'(bus.out_valid[c]), 32'(0));
      checkOutput($sformatf("reset.data%0d", c), 32'(bus.out_data[c]), 32'(0));
    end
    checkOutput("reset.last", 32'(bus.last_channel), 32'(0));
    checkOutput("reset.pulse", 32'(bus.dispatch_pulse), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] continuous drain");
    for (int i = 0; i < 4; i++) begin
      applyStimulus("drain", 1'b1, words[i], 4'b1111, 4'b1111);
      checkOutput("drain.data3", 32'(bus.out_data[3]), 32'(words[i]));
      checkOutput("drain.last", 32'(bus.last_channel), 32'(3));
    end

    $display("[TB] fill order");
    applyStimulus("fill.idle", 1'b0, 8'h00, 4'b1111, 4'b1111);
    for (int i = 0; i < 5; i++)
      applyStimulus("fill", 1'b1, words[i], 4'b1111, 4'b0000);
    applyStimulus("fill.hold", 1'b1, words[4], 4'b1111, 4'b0000);
    checkOutput("fill.ch3", 32'(bus.out_data[3]), 32'(1));
    checkOutput("fill.ch1", 32'(bus.out_data[1]), 32'(3));
    checkOutput("fill.ch2", 32'(bus.out_data[2]), 32'(5));
    checkOutput("fill.ch0", 32'(bus.out_data[0]), 32'(7));
    checkOutput("fill.stall", 32'(bus.in_ready), 32'(0));
    applyStimulus("fill.release", 1'b1, words[4], 4'b1111, 4'b1111);
    applyStimulus("fill.empty", 1'b0, 8'h00, 4'b1111, 4'b1111);

    $display("[TB] enable mask");
    applyStimulus("mask", 1'b1, 8'd1, 4'b1010, 4'b0000);
    applyStimulus("mask", 1'b1, 8'd3, 4'b1010, 4'b0000);
    applyStimulus("mask.stall", 1'b0, 8'h00, 4'b1010, 4'b0000);
    checkOutput("mask.ch3", 32'(bus.out_data[3]), 32'(1));
    checkOutput("mask.ch1", 32'(bus.out_data[1]), 32'(3));
    checkOutput("mask.in_ready", 32'(bus.in_ready), 32'(0));
    checkOutput("mask.valid0", 32'(bus.out_valid[0]), 32'(0));
    checkOutput("mask.valid2", 32'(bus.out_valid[2]), 32'(0));

    $display("[TB] same-cycle drain and refill");
    applyStimulus("refill", 1'b1, 8'd9, 4'b1111, 4'b1000);
    checkOutput("refill.data3", 32'(bus.out_data[3]), 32'(9));
    checkOutput("refill.valid3", 32'(bus.out_valid[3]), 32'(1));
    checkOutput("refill.pulse", 32'(bus.dispatch_pulse), 32'(1));
    checkOutput("refill.last", 32'(bus.last_channel), 32'(3));

    $display("[TB] disable while full");
    applyStimulus("dis.empty", 1'b0, 8'h00, 4'b1111, 4'b1111);
    applyStimulus("dis.load", 1'b1, 8'd5, 4'b1111, 4'b0000);
    applyStimulus("dis.push", 1'b1, 8'd7, 4'b0111, 4'b0000);
    checkOutput("dis.ch1", 32'(bus.out_data[1]), 32'(7));
    checkOutput("dis.last", 32'(bus.last_channel), 32'(1));
    applyStimulus("dis.hold", 1'b0, 8'h00, 4'b0111, 4'b0000);
    checkOutput("dis.valid3.held", 32'(bus.out_valid[3]), 32'(1));
    applyStimulus("dis.drain", 1'b0, 8'h00, 4'b0111, 4'b1000);
    checkOutput("dis.valid3.cleared", 32'(bus.out_valid[3]), 32'(0));

    $display("[TB] mid-operation reset");
    applyStimulus("rst.empty", 1'b0, 8'h00, 4'b1111, 4'b1111);
    for (int i = 0; i < 4; i++)
      applyStimulus("rst.fill", 1'b1, words[i], 4'b1111, 4'b0000);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++)
      checkOutput($sformatf("rst.valid%0d", c), 32'(bus.out_valid[c]), 32'(0));
    checkOutput("rst.in_ready", 32'(bus.in_ready), 32'(0));
    model_clear();
    tick();
    #2;
    rst_n = 1'b1;
    applyStimulus("rst.idle", 1'b0, 8'h00, 4'b1111, 4'b0000);
    applyStimulus("rst.push", 1'b1, 8'd1, 4'b1111, 4'b0000);
    checkOutput("rst.first.valid3", 32'(bus.out_valid[3]), 32'(1));
    checkOutput("rst.first.data3", 32'(bus.out_data[3]), 32'(1));

    $display("[TB] random traffic");
    v = 1'b0;
    d = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (!(v && !m_acc)) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
      end
      applyStimulus("rand", v, d, 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
